// File: rtl/codix_risc_bus_arb_pkg.sv
// Shared encodings for the ibus/dbus memory-port arbiter.
package codix_risc_bus_arb_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_READ  = 2'd1,
    CMD_WRITE = 2'd2
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT_I = 3'd1,
    GRANT_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } state_e;

  localparam int          TIMEOUT_DEF = 64;
  localparam logic [1:0]  SIZE_WORD   = 2'd2;

endpackage

// File: rtl/codix_risc_rr_arb2.sv
// Two-way round-robin pick: bit0 = ibus, bit1 = dbus; a tie goes to the side not served last.
module codix_risc_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/codix_risc_bus_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction in flight.
module codix_risc_bus_arbiter
  import codix_risc_bus_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] ibus_A0,
  input  logic [1:0]        ibus_REQCMD0,
  output logic              ibus_REQRESP0,
  output logic [DATA_W-1:0] ibus_Q0,
  output logic              ibus_IFRESP0,
  input  logic [ADDR_W-1:0] dbus_A0,
  input  logic [1:0]        dbus_SI0,
  input  logic [1:0]        dbus_REQCMD0,
  input  logic [DATA_W-1:0] dbus_D0,
  output logic              dbus_REQRESP0,
  output logic [DATA_W-1:0] dbus_Q0,
  output logic              dbus_IFRESP0,
  output logic [ADDR_W-1:0] mem_A0,
  output logic [1:0]        mem_SI0,
  output logic [1:0]        mem_REQCMD0,
  output logic [DATA_W-1:0] mem_D0,
  input  logic              mem_REQRESP0,
  input  logic [DATA_W-1:0] mem_Q0,
  input  logic              mem_IFRESP0,
  output logic              err
);

  state_e     state;
  logic       last_d;    // 1: dbus was the last requester accepted
  logic [7:0] wait_cnt;
  logic       req_i, req_d, ill_i, timeout_hit;
  logic [1:0] gnt;

  // ibus WRITE is illegal and never counts as a request
  assign req_i       = (ibus_REQCMD0 == CMD_READ);
  assign ill_i       = (ibus_REQCMD0 == CMD_WRITE);
  assign req_d       = (dbus_REQCMD0 == CMD_READ) || (dbus_REQCMD0 == CMD_WRITE);
  assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

  codix_risc_rr_arb2 u_rr (
    .req  ({req_d, req_i}),
    .last (last_d),
    .gnt  (gnt)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      last_d   <= 1'b0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt[1])      state <= GRANT_D;
          else if (gnt[0]) state <= GRANT_I;
        end
        GRANT_I: begin
          if (!req_i) state <= IDLE;
          else if (mem_REQRESP0) begin
            state    <= RESP_I;
            last_d   <= 1'b0;
            wait_cnt <= '0;
          end
        end
        GRANT_D: begin
          if (!req_d) state <= IDLE;
          else if (mem_REQRESP0) begin
            state    <= (dbus_REQCMD0 == CMD_READ) ? RESP_D : IDLE;
            last_d   <= 1'b1;
            wait_cnt <= '0;
          end
        end
        RESP_I, RESP_D: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (mem_IFRESP0 || timeout_hit) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are combinational so acceptance and read data reach the owner with zero latency;
  // RST gates them so nothing leaks while the state is being forced.
  always_comb begin
    mem_A0        = '0;
    mem_SI0       = '0;
    mem_REQCMD0   = CMD_IDLE;
    mem_D0        = '0;
    ibus_REQRESP0 = 1'b0;
    ibus_IFRESP0  = 1'b0;
    ibus_Q0       = '0;
    dbus_REQRESP0 = 1'b0;
    dbus_IFRESP0  = 1'b0;
    dbus_Q0       = '0;
    err           = 1'b0;
    if (!RST) begin
      case (state)
        IDLE: err = ill_i | mem_IFRESP0;
        GRANT_I: begin
          mem_A0        = ibus_A0;
          mem_SI0       = SIZE_WORD;
          mem_REQCMD0   = req_i ? CMD_READ : CMD_IDLE;
          ibus_REQRESP0 = req_i & mem_REQRESP0;
          err           = mem_IFRESP0;
        end
        GRANT_D: begin
          mem_A0        = dbus_A0;
          mem_SI0       = dbus_SI0;
          mem_REQCMD0   = req_d ? dbus_REQCMD0 : 2'(CMD_IDLE);
          mem_D0        = dbus_D0;
          dbus_REQRESP0 = req_d & mem_REQRESP0;
          err           = mem_IFRESP0;
        end
        RESP_I: begin
          if (mem_IFRESP0) begin
            ibus_IFRESP0 = 1'b1;
            ibus_Q0      = mem_Q0;
          end else begin
            err = timeout_hit;
          end
        end
        RESP_D: begin
          if (mem_IFRESP0) begin
            dbus_IFRESP0 = 1'b1;
            dbus_Q0      = mem_Q0;
          end else begin
            err = timeout_hit;
          end
        end
        default: err = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_codix_risc_bus_arbiter.sv
// Directed scenarios plus a randomized traffic phase checked against a transaction-level model.
module tb_codix_risc_bus_arbiter;
  import codix_risc_bus_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 64;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] ibus_A0, dbus_A0, mem_A0;
  logic [1:0]    ibus_REQCMD0, dbus_SI0, dbus_REQCMD0, mem_SI0, mem_REQCMD0;
  logic [DW-1:0] dbus_D0, ibus_Q0, dbus_Q0, mem_D0, mem_Q0;
  logic          ibus_REQRESP0, ibus_IFRESP0, dbus_REQRESP0, dbus_IFRESP0;
  logic          mem_REQRESP0, mem_IFRESP0, err;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  codix_risc_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST),
    .ibus_A0(ibus_A0), .ibus_REQCMD0(ibus_REQCMD0), .ibus_REQRESP0(ibus_REQRESP0),
    .ibus_Q0(ibus_Q0), .ibus_IFRESP0(ibus_IFRESP0),
    .dbus_A0(dbus_A0), .dbus_SI0(dbus_SI0), .dbus_REQCMD0(dbus_REQCMD0), .dbus_D0(dbus_D0),
    .dbus_REQRESP0(dbus_REQRESP0), .dbus_Q0(dbus_Q0), .dbus_IFRESP0(dbus_IFRESP0),
    .mem_A0(mem_A0), .mem_SI0(mem_SI0), .mem_REQCMD0(mem_REQCMD0), .mem_D0(mem_D0),
    .mem_REQRESP0(mem_REQRESP0), .mem_Q0(mem_Q0), .mem_IFRESP0(mem_IFRESP0),
    .err(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    ibus_A0 = '0; ibus_REQCMD0 = 2'd0;
    dbus_A0 = '0; dbus_SI0 = 2'd0; dbus_REQCMD0 = 2'd0; dbus_D0 = '0;
    mem_REQRESP0 = 1'b0; mem_Q0 = '0; mem_IFRESP0 = 1'b0;
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic chk_quiet(input string tag, input logic exp_err);
    chk({tag, "_resp"}, 64'({ibus_REQRESP0, ibus_IFRESP0, dbus_REQRESP0, dbus_IFRESP0}), 64'(0));
    chk({tag, "_q"}, {ibus_Q0, dbus_Q0}, 64'(0));
    chk({tag, "_mem"}, 64'({mem_SI0, mem_REQCMD0, mem_D0}), 64'(0));
    chk({tag, "_addr"}, 64'(mem_A0), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
  endtask

  // Random traffic: requesters hold a request until accepted, the memory accepts and answers
  // after random delays. Expected owner comes from who was requesting in the arbitration cycle
  // and who was served last.
  task automatic run_rand(input int ntxn, input int max_gap);
    bit i_pend = 0, d_pend = 0, i_wait = 0, d_wait = 0;
    bit pi_prev = 0, pd_prev = 0, pi_drv, pd_drv;
    bit in_cmd = 0, rd_out = 0, acc, resp_now;
    int i_gap = 0, d_gap = 0, last = 0, owner = 0, prev_owner = -1;
    int rd_owner = 0, rd_delay = 0, done = 0, ncyc = 0;
    logic [AW-1:0] ia = '0, da = '0;
    logic [DW-1:0] dd = '0, rd_data = '0;
    logic [1:0]    dc = 2'd1, ds = 2'd0;
    drive_idle();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    while (done < ntxn && ncyc < 6000) begin
      ncyc++;
      if (!i_pend && !i_wait) begin
        if (i_gap == 0) begin i_pend = 1; ia = $urandom; end
        else i_gap--;
      end
      if (!d_pend && !d_wait) begin
        if (d_gap == 0) begin
          d_pend = 1; da = $urandom; dd = $urandom;
          dc = 2'($urandom_range(1, 2)); ds = 2'($urandom_range(0, 2));
        end else d_gap--;
      end
      pi_drv = i_pend; pd_drv = d_pend;
      ibus_REQCMD0 = i_pend ? 2'd1 : 2'd0; ibus_A0 = ia;
      dbus_REQCMD0 = d_pend ? dc : 2'd0; dbus_A0 = da; dbus_SI0 = ds; dbus_D0 = dd;
      acc = ($urandom_range(0, 2) != 0);
      resp_now = rd_out && (rd_delay == 0);
      mem_REQRESP0 = acc;
      mem_IFRESP0 = resp_now;
      mem_Q0 = resp_now ? rd_data : $urandom;
      smp();
      chk("rnd_err", 64'(err), 64'(0));
      if (resp_now) begin
        chk("rnd_rvld", 64'({ibus_IFRESP0, dbus_IFRESP0}), (rd_owner == 0) ? 64'(2) : 64'(1));
        chk("rnd_rdata", (rd_owner == 0) ? 64'(ibus_Q0) : 64'(dbus_Q0), 64'(rd_data));
        chk("rnd_rq_other", (rd_owner == 0) ? 64'(dbus_Q0) : 64'(ibus_Q0), 64'(0));
        rd_out = 0;
        if (rd_owner == 0) i_wait = 0; else d_wait = 0;
      end else begin
        chk("rnd_no_rvld", 64'({ibus_IFRESP0, dbus_IFRESP0}), 64'(0));
        chk("rnd_q_zero", {ibus_Q0, dbus_Q0}, 64'(0));
        if (rd_out) rd_delay--;
      end
      if (mem_REQCMD0 != 2'd0) begin
        if (!in_cmd) begin
          chk("rnd_single", 64'(rd_out), 64'(0));
          chk("rnd_had_req", 64'(pi_prev | pd_prev), 64'(1));
          owner = (pi_prev && pd_prev) ? 1 - last : (pd_prev ? 1 : 0);
          in_cmd = 1;
        end
        if (owner == 0) begin
          chk("rnd_i_cmd", 64'({mem_SI0, mem_REQCMD0}), 64'({2'd2, 2'd1}));
          chk("rnd_i_addr", 64'(mem_A0), 64'(ia));
          chk("rnd_i_data", 64'(mem_D0), 64'(0));
        end else begin
          chk("rnd_d_cmd", 64'({mem_SI0, mem_REQCMD0}), 64'({ds, dc}));
          chk("rnd_d_addr", 64'(mem_A0), 64'(da));
          chk("rnd_d_data", 64'(mem_D0), 64'(dd));
        end
        chk("rnd_acc", 64'({ibus_REQRESP0, dbus_REQRESP0}),
            !acc ? 64'(0) : (owner == 0) ? 64'(2) : 64'(1));
        if (acc) begin
          in_cmd = 0;
          last = owner;
          done++;
          if (max_gap == 0 && prev_owner >= 0) chk("rnd_alternate", 64'(owner != prev_owner), 64'(1));
          prev_owner = owner;
          if (owner == 0) begin
            i_pend = 0; i_wait = 1; i_gap = $urandom_range(0, max_gap);
            rd_out = 1; rd_owner = 0;
          end else begin
            d_pend = 0; d_gap = $urandom_range(0, max_gap);
            if (dc == 2'd1) begin d_wait = 1; rd_out = 1; rd_owner = 1; end
          end
          if (rd_out) begin rd_data = $urandom; rd_delay = $urandom_range(0, 3); end
        end
      end else begin
        chk("rnd_no_acc", 64'({ibus_REQRESP0, dbus_REQRESP0}), 64'(0));
        chk("rnd_cmd_held", 64'(in_cmd), 64'(0));
        in_cmd = 0;
      end
      pi_prev = pi_drv; pd_prev = pd_drv;
      cyc();
    end
    chk("rnd_budget", 64'(done >= ntxn), 64'(1));
    drive_idle();
  endtask

  initial begin
    drive_idle();
    RST = 1'b1;
    // reset: outputs stay quiet even with activity on the inputs
    cyc();
    ibus_REQCMD0 = 2'd1; mem_IFRESP0 = 1'b1; mem_Q0 = 32'hFFFF_FFFF;
    smp(); chk_quiet("rst_busy", 1'b0);
    cyc(); drive_idle();
    smp(); chk_quiet("rst", 1'b0);
    cyc(); RST = 1'b0;
    smp(); chk_quiet("idle", 1'b0);

    // simultaneous reads: dbus first, then ibus, data routed to each owner
    cyc();
    ibus_REQCMD0 = 2'd1; ibus_A0 = 32'h100;
    dbus_REQCMD0 = 2'd1; dbus_A0 = 32'h200; dbus_SI0 = 2'd2; dbus_D0 = 32'h5555;
    smp(); chk("tie_idle_cmd", 64'(mem_REQCMD0), 64'(0));
    cyc(); mem_REQRESP0 = 1'b1;
    smp();
    chk("tie_d_addr", 64'(mem_A0), 64'(32'h200));
    chk("tie_d_cmd", 64'(mem_REQCMD0), 64'(1));
    chk("tie_d_acc", 64'({ibus_REQRESP0, dbus_REQRESP0}), 64'(1));
    cyc(); dbus_REQCMD0 = 2'd0; mem_REQRESP0 = 1'b0; mem_IFRESP0 = 1'b1; mem_Q0 = 32'h1111_2222;
    smp();
    chk("d_rdata", 64'(dbus_Q0), 64'(32'h1111_2222));
    chk("d_rvld", 64'({ibus_IFRESP0, dbus_IFRESP0}), 64'(1));
    chk("d_rd_iq", 64'(ibus_Q0), 64'(0));
    chk("resp_nocmd", 64'(mem_REQCMD0), 64'(0));
    cyc(); mem_IFRESP0 = 1'b0;
    smp(); chk_quiet("turn_idle", 1'b0);
    cyc(); mem_REQRESP0 = 1'b1; dbus_SI0 = 2'd1;
    smp();
    chk("i_addr", 64'(mem_A0), 64'(32'h100));
    chk("i_si_d", 64'({mem_SI0, mem_D0}), 64'({2'd2, 32'd0}));
    chk("i_acc", 64'({ibus_REQRESP0, dbus_REQRESP0}), 64'(2));
    cyc(); ibus_REQCMD0 = 2'd0; mem_REQRESP0 = 1'b0; mem_IFRESP0 = 1'b1; mem_Q0 = 32'h3333_4444;
    smp();
    chk("i_rdata", 64'(ibus_Q0), 64'(32'h3333_4444));
    chk("i_rvld", 64'({ibus_IFRESP0, dbus_IFRESP0}), 64'(2));
    chk("i_rd_dq", 64'(dbus_Q0), 64'(0));
    cyc(); drive_idle();
    smp(); chk_quiet("after_i", 1'b0);

    // write held three cycles before acceptance, then IDLE (stray response there only errs)
    cyc();
    dbus_REQCMD0 = 2'd2; dbus_A0 = 32'h40; dbus_D0 = 32'hDEAD_BEEF; dbus_SI0 = 2'd2;
    smp(); chk_quiet("wr_idle", 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(); smp();
      chk("wr_hold_mem", 64'({mem_A0, mem_SI0, mem_REQCMD0}), 64'({32'h40, 2'd2, 2'd2}));
      chk("wr_hold_d", 64'(mem_D0), 64'(32'hDEAD_BEEF));
      chk("wr_hold_noack", 64'(dbus_REQRESP0), 64'(0));
    end
    cyc(); mem_REQRESP0 = 1'b1;
    smp();
    chk("wr_acc", 64'({ibus_REQRESP0, dbus_REQRESP0}), 64'(1));
    chk("wr_acc_d", 64'(mem_D0), 64'(32'hDEAD_BEEF));
    cyc(); dbus_REQCMD0 = 2'd0; mem_REQRESP0 = 1'b0; mem_IFRESP0 = 1'b1; mem_Q0 = 32'h77;
    smp(); chk_quiet("wr_idle_stray", 1'b1);
    cyc(); drive_idle();
    smp(); chk_quiet("stray_done", 1'b0);

    // withdrawal before acceptance: no command, pointer stays on dbus so ibus wins the next tie
    cyc(); ibus_REQCMD0 = 2'd1; ibus_A0 = 32'h80;
    smp();
    cyc(); ibus_REQCMD0 = 2'd0;
    smp();
    chk("wd_nocmd", 64'(mem_REQCMD0), 64'(0));
    chk("wd_noack", 64'(ibus_REQRESP0), 64'(0));
    cyc();
    ibus_REQCMD0 = 2'd1; ibus_A0 = 32'h84; dbus_REQCMD0 = 2'd1; dbus_A0 = 32'h88;
    smp(); chk_quiet("wd_idle", 1'b0);
    cyc(); smp();
    chk("wd_ptr_kept", 64'(mem_A0), 64'(32'h84));
    chk("wd_ptr_cmd", 64'(mem_REQCMD0), 64'(1));
    cyc(); drive_idle();
    smp(); chk("wd_drop", 64'(mem_REQCMD0), 64'(0));

    // read timeout: err on the TO-th waiting cycle, no data to ibus, then dbus is served
    cyc(); ibus_REQCMD0 = 2'd1; ibus_A0 = 32'h300;
    smp();
    cyc(); mem_REQRESP0 = 1'b1;
    smp(); chk("to_acc", 64'(ibus_REQRESP0), 64'(1));
    cyc(); ibus_REQCMD0 = 2'd0; mem_REQRESP0 = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      smp();
      chk("to_err", 64'(err), 64'(k == TO));
      chk("to_novld", 64'({ibus_IFRESP0, ibus_Q0}), 64'(0));
      cyc();
    end
    dbus_REQCMD0 = 2'd1; dbus_A0 = 32'h400;
    smp(); chk_quiet("to_idle", 1'b0);
    cyc(); mem_REQRESP0 = 1'b1;
    smp();
    chk("to_next_acc", 64'({ibus_REQRESP0, dbus_REQRESP0}), 64'(1));
    chk("to_next_addr", 64'(mem_A0), 64'(32'h400));

    // reset mid-read: the late response is only an error
    cyc(); dbus_REQCMD0 = 2'd0; mem_REQRESP0 = 1'b0;
    smp(); chk("rd_wait", 64'(dbus_IFRESP0), 64'(0));
    cyc(); RST = 1'b1;
    smp(); chk_quiet("rst_in_resp", 1'b0);
    cyc(); RST = 1'b0;
    smp(); chk_quiet("rst_after", 1'b0);
    cyc(); mem_IFRESP0 = 1'b1; mem_Q0 = 32'hCAFE;
    smp(); chk_quiet("late_resp", 1'b1);

    // reset returns the pointer to ibus, so dbus wins the first tie
    cyc(); drive_idle();
    ibus_REQCMD0 = 2'd1; ibus_A0 = 32'h500; dbus_REQCMD0 = 2'd1; dbus_A0 = 32'h600;
    smp();
    cyc(); smp(); chk("rst_ptr", 64'(mem_A0), 64'(32'h600));
    cyc(); drive_idle();
    cyc();

    // ibus WRITE is never granted
    ibus_REQCMD0 = 2'd2; ibus_A0 = 32'h700;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("iw_err", 64'(err), 64'(1));
      chk("iw_nocmd", 64'(mem_REQCMD0), 64'(0));
      chk("iw_noack", 64'(ibus_REQRESP0), 64'(0));
      cyc();
    end
    drive_idle();
    smp(); chk_quiet("iw_done", 1'b0);
    cyc();

    run_rand(20, 0);
    run_rand(300, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/codix_risc_bus_arbiter.md
CODIX_RISC_BUS_ARBITER -- requirements
Module: codix_risc_bus_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width; TIMEOUT, 64, maximum read-response wait in cycles (range 2..255).
REQ-002 Ports SHALL be, one per line:
  CLK  in  1  sole clock, rising edge.
  RST  in  1  reset, synchronous, active-high.
  ibus_A0  in  ADDR_W  instruction-fetch address.
  ibus_REQCMD0  in  2  fetch command (IDLE=0, READ=1; WRITE=2 illegal).
  ibus_REQRESP0  out  1  fetch command accepted.
  ibus_Q0  out  DATA_W  fetch read data.
  ibus_IFRESP0  out  1  fetch read data valid.
  dbus_A0  in  ADDR_W  data address.
  dbus_SI0  in  2  data access size.
  dbus_REQCMD0  in  2  data command (IDLE=0, READ=1, WRITE=2).
  dbus_D0  in  DATA_W  write data.
  dbus_REQRESP0  out  1  data command accepted.
  dbus_Q0  out  DATA_W  data read data.
  dbus_IFRESP0  out  1  data read data valid.
  mem_A0, mem_SI0, mem_REQCMD0, mem_D0  out  ADDR_W/2/2/DATA_W  shared memory port command.
  mem_REQRESP0  in  1  memory accepted command.
  mem_Q0  in  DATA_W  memory read data.
  mem_IFRESP0  in  1  memory read data valid.
  err  out  1  one-cycle protocol/timeout error pulse.

Function
REQ-003 The block SHALL share one memory port between ibus and dbus, with at most one transaction outstanding.
REQ-004 FSM states SHALL be IDLE, GRANT_I, GRANT_D, RESP_I, RESP_D.
REQ-005 IDLE: one requester non-IDLE -> GRANT of that requester next cycle; both -> round-robin, the requester not granted last wins.
REQ-006 GRANT_x: mem_A0/SI0/REQCMD0/D0 SHALL be muxed combinationally from owner x; ibus grant drives mem_SI0=2 (word) and mem_D0=0.
REQ-007 GRANT_x with mem_REQRESP0=1: owner REQRESP0 SHALL pulse high the same cycle; READ -> RESP_x, WRITE -> IDLE; round-robin pointer updated to x.
REQ-008 GRANT_x with owner REQCMD0 returning to IDLE before acceptance -> IDLE next cycle, no memory command, pointer unchanged.
REQ-009 RESP_x: mem_REQCMD0=IDLE; on mem_IFRESP0=1, owner Q0=mem_Q0 and owner IFRESP0=1 in the same cycle (zero latency), then IDLE.
REQ-010 Minimum read turnaround SHALL be: request in IDLE at cycle N, command at N+1, data no earlier than N+2, next arbitration at IDLE one cycle after data.
REQ-011 An 8-bit wait counter SHALL clear on entry to RESP_x and increment each RESP_x cycle; reaching TIMEOUT -> err pulse, IDLE, no IFRESP0 to owner.
REQ-012 mem_IFRESP0=1 in IDLE or GRANT_x (stray or late response) SHALL be ignored except for an err pulse.
REQ-013 ibus_REQCMD0=WRITE SHALL never be granted; err pulses on each cycle it is presented in IDLE.
REQ-014 Non-owner REQRESP0/IFRESP0 SHALL be 0; Q0 outputs SHALL be 0 when the corresponding IFRESP0 is 0.

Reset
REQ-015 RST=1 at a clock edge SHALL force IDLE, pointer=ibus (dbus wins first tie), wait counter=0, from any state including RESP_x.
REQ-016 During and after reset: all REQRESP0/IFRESP0=0, Q0=0, mem_REQCMD0=IDLE, mem_A0/SI0/D0=0, err=0; a response arriving after mid-read reset SHALL be treated per REQ-012.

Structure
REQ-017 Package codix_risc_bus_arb_pkg SHALL hold the command encoding enum, FSM state enum and TIMEOUT default.
REQ-018 Two-way round-robin selection SHALL be one sub-module, codix_risc_rr_arb2 (requests, last-grant pointer in, grant out).

Verification
REQ-019 Both idle reset, then ibus READ 0x100 and dbus READ 0x200 in the same cycle -> dbus command first, ibus next; Q routed to correct owner.
REQ-020 dbus WRITE 0x40 D0=0xDEADBEEF, mem_REQRESP0 delayed 3 cycles -> mem port holds values 3 cycles, dbus_REQRESP0 single pulse, IDLE next.
REQ-021 ibus READ, memory never responds -> err pulse after 64 RESP cycles, no ibus_IFRESP0, next request served.
REQ-022 RST asserted in RESP_D, memory responds 2 cycles later -> no dbus_IFRESP0, err pulse, outputs at reset values.
REQ-023 Continuous requests from both for 20 transactions -> strict alternation, no starvation, one outstanding at a time.
REQ-024 ibus WRITE presented -> never granted, err pulses, mem_REQCMD0 stays IDLE.
